// File: rtl/wr_resp_arb.sv
// ============================================================================
// wr_resp_arb : round-robin arbiter merging slave AXI B channels onto one
//               registered master B channel, with an error-response counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wr_resp_arb #(
   parameter int NUM_SLV = 8,
   parameter int ID_W    = 4,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_SLV*ID_W-1:0] s_bid,
   input  logic [NUM_SLV*2-1:0]    s_bresp,
   input  logic [NUM_SLV-1:0]      s_bvalid,
   output logic [NUM_SLV-1:0]      s_bready,
   output logic [ID_W-1:0]         m00_axi_bid,
   output logic [1:0]              m00_axi_bresp,
   output logic                    m00_axi_bvalid,
   input  logic                    m00_axi_bready,
   input  logic                    err_clr,
   output logic [CNT_W-1:0]        err_cnt
);

   localparam int         PTR_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   cand;
   logic               grant_vld;
   logic               load_ok;
   logic               slv_hs;
   logic               mst_err_hs;
   logic [NUM_SLV-1:0] eligible;

   // A slave is eligible when valid and its BID routing field matches sel
   for (genvar k = 0; k < NUM_SLV; k++) begin : g_elig
      assign eligible[k] = s_bvalid[k] &&
                           (s_bid[k*ID_W + ID_W - SEL_W +: SEL_W] == sel);
   end

   // Round-robin search starting one past the last granted slave
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         cand = PTR_W'((int'(rr_ptr) + 1 + i) % NUM_SLV);
         if (!grant_vld && eligible[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      load_ok   = (state == EMPTY) | m00_axi_bready;
      slv_hs    = grant_vld & load_ok & ~reset;
      state_nxt = state;
      s_bready  = '0;
      if (slv_hs) begin
         s_bready[grant_idx] = 1'b1;
         state_nxt           = FULL;
      end else if ((state == FULL) && m00_axi_bready) begin
         state_nxt = EMPTY;
      end
   end

   assign m00_axi_bvalid = (state == FULL);

   always_ff @(posedge clk) begin
      if (reset) begin
         m00_axi_bid   <= '0;
         m00_axi_bresp <= '0;
         rr_ptr        <= PTR_W'(NUM_SLV - 1);
      end else if (slv_hs) begin
         m00_axi_bid   <= s_bid[grant_idx*ID_W +: ID_W];
         m00_axi_bresp <= s_bresp[grant_idx*2 +: 2];
         rr_ptr        <= grant_idx;
      end
   end

   // SLVERR and DECERR both have bresp[1] set
   assign mst_err_hs = (state == FULL) & m00_axi_bready & m00_axi_bresp[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (mst_err_hs && (err_cnt != CNT_MAX)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wr_resp_arb.sv
// Directed self-checking bench for wr_resp_arb (default and CNT_W=2 instances).
`default_nettype none

module tb_wr_resp_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  sel;
   logic [31:0] s_bid;
   logic [15:0] s_bresp;
   logic [7:0]  s_bvalid;
   logic [7:0]  s_bready, s_bready2;
   logic [3:0]  m_bid, m_bid2;
   logic [1:0]  m_bresp, m_bresp2;
   logic        m_bvalid, m_bvalid2;
   logic        m_bready;
   logic        err_clr;
   logic [15:0] err_cnt;
   logic [1:0]  err_cnt2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wr_resp_arb dut (
      .clk(clk), .reset(reset), .sel(sel), .s_bid(s_bid), .s_bresp(s_bresp),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .m00_axi_bid(m_bid),
      .m00_axi_bresp(m_bresp), .m00_axi_bvalid(m_bvalid),
      .m00_axi_bready(m_bready), .err_clr(err_clr), .err_cnt(err_cnt)
   );

   wr_resp_arb #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .sel(sel), .s_bid(s_bid), .s_bresp(s_bresp),
      .s_bvalid(s_bvalid), .s_bready(s_bready2), .m00_axi_bid(m_bid2),
      .m00_axi_bresp(m_bresp2), .m00_axi_bvalid(m_bvalid2),
      .m00_axi_bready(m_bready), .err_clr(err_clr), .err_cnt(err_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic slv(input int k, input logic v, input logic [3:0] id, input logic [1:0] r);
      s_bvalid[k]       = v;
      s_bid[k*4 +: 4]   = id;
      s_bresp[k*2 +: 2] = r;
   endtask

   logic [7:0] fr_rdy [6] = '{8'h01, 8'h08, 8'h20, 8'h01, 8'h08, 8'h20};
   logic [3:0] fr_bid [6] = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3};

   initial begin
      reset = 1'b1; sel = 2'd0; s_bid = '0; s_bresp = '0; s_bvalid = '0;
      m_bready = 1'b1; err_clr = 1'b0;
      slv(0, 1'b1, 4'h1, 2'b00);

      // Reset state, with an eligible slave present
      repeat (2) @(negedge clk);
      #1;
      chk("rst_bvalid", m_bvalid, 0);
      chk("rst_bid", m_bid, 0);
      chk("rst_bresp", m_bresp, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_s_bready", s_bready, 0);

      // Round-robin fairness among slaves 0, 3, 5
      @(negedge clk);
      reset = 1'b0;
      slv(0, 1'b1, 4'h1, 2'b00);
      slv(3, 1'b1, 4'h2, 2'b00);
      slv(5, 1'b1, 4'h3, 2'b00);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         chk($sformatf("fair_rdy%0d", c), s_bready, fr_rdy[c]);
         chk($sformatf("fair_bvalid%0d", c), m_bvalid, (c > 0));
         if (c > 0) chk($sformatf("fair_bid%0d", c), m_bid, fr_bid[c-1]);
      end
      @(negedge clk);
      slv(0, 1'b0, 4'h0, 2'b00); slv(3, 1'b0, 4'h0, 2'b00); slv(5, 1'b0, 4'h0, 2'b00);
      #1;
      chk("fair_tail_rdy", s_bready, 0);
      chk("fair_tail_bvalid", m_bvalid, 1);
      chk("fair_tail_bid", m_bid, 4'h3);
      @(negedge clk); #1;
      chk("fair_empty", m_bvalid, 0);

      // Single response through routing field 1
      sel = 2'd1;
      slv(2, 1'b1, 4'h5, 2'b00);
      #1;
      chk("single_rdy", s_bready, 8'h04);
      @(negedge clk);
      slv(2, 1'b0, 4'h0, 2'b00);
      #1;
      chk("single_bvalid", m_bvalid, 1);
      chk("single_bid", m_bid, 4'h5);
      chk("single_bresp", m_bresp, 0);
      @(negedge clk); #1;
      chk("single_empty", m_bvalid, 0);

      // Backpressure: hold slave 6 response while slave 1 waits
      sel = 2'd0;
      slv(6, 1'b1, 4'h3, 2'b00);
      #1;
      chk("bp_load_rdy", s_bready, 8'h40);
      @(negedge clk);
      slv(6, 1'b0, 4'h0, 2'b00);
      slv(1, 1'b1, 4'h1, 2'b01);
      m_bready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         sel = (c == 2 || c == 3) ? 2'd3 : 2'd0;
         #1;
         chk($sformatf("bp_rdy%0d", c), s_bready, 0);
         chk($sformatf("bp_bvalid%0d", c), m_bvalid, 1);
         chk($sformatf("bp_bid%0d", c), m_bid, 4'h3);
         chk($sformatf("bp_bresp%0d", c), m_bresp, 0);
      end
      @(negedge clk);
      m_bready = 1'b1;
      #1;
      chk("bp_release_rdy", s_bready, 8'h02);
      @(negedge clk);
      slv(1, 1'b0, 4'h0, 2'b00);
      #1;
      chk("bp_new_bid", m_bid, 4'h1);
      chk("bp_new_bresp", m_bresp, 2'b01);
      chk("bp_new_bvalid", m_bvalid, 1);
      @(negedge clk); #1;
      chk("bp_empty", m_bvalid, 0);

      // Filter: wrong routing field never granted
      sel = 2'd2;
      slv(4, 1'b1, 4'h3, 2'b00);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         chk($sformatf("filt_rdy%0d", c), s_bready, 0);
         chk($sformatf("filt_bvalid%0d", c), m_bvalid, 0);
      end
      @(negedge clk);
      slv(4, 1'b0, 4'h0, 2'b00);

      // Error counting: 10,10,10,11 then 10 with err_clr
      sel = 2'd0;
      slv(0, 1'b1, 4'h0, 2'b10);
      #1;
      chk("err_rdy", s_bready, 8'h01);
      chk("err_cnt0", err_cnt, 0);
      @(negedge clk); #1;
      chk("err_cnt_p0", err_cnt, 0);
      chk("err_bresp_p0", m_bresp, 2'b10);
      @(negedge clk); #1;
      chk("err_cnt_p1", err_cnt, 1);
      @(negedge clk);
      slv(0, 1'b1, 4'h0, 2'b11);
      #1;
      chk("err_cnt_p2", err_cnt, 2);
      @(negedge clk);
      slv(0, 1'b1, 4'h0, 2'b10);
      #1;
      chk("err_cnt_p3", err_cnt, 3);
      chk("err_sat_p3", err_cnt2, 3);
      chk("err_bresp_p3", m_bresp, 2'b11);
      @(negedge clk);
      slv(0, 1'b0, 4'h0, 2'b00);
      err_clr = 1'b1;
      #1;
      chk("err_cnt_p4", err_cnt, 4);
      chk("err_sat_p4", err_cnt2, 3);
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      chk("err_clr_cnt", err_cnt, 0);
      chk("err_clr_sat", err_cnt2, 0);
      chk("err_clr_bvalid", m_bvalid, 0);

      // Reset while FULL under backpressure
      slv(3, 1'b1, 4'h2, 2'b00);
      #1;
      chk("mr_rdy", s_bready, 8'h08);
      @(negedge clk);
      slv(3, 1'b0, 4'h0, 2'b00);
      m_bready = 1'b0;
      #1;
      chk("mr_full", m_bvalid, 1);
      @(negedge clk);
      reset = 1'b1;
      slv(0, 1'b1, 4'h1, 2'b00);
      slv(5, 1'b1, 4'h3, 2'b00);
      #1;
      chk("mr_rdy_in_reset", s_bready, 0);
      @(negedge clk);
      reset = 1'b0;
      m_bready = 1'b1;
      #1;
      chk("mr_bvalid", m_bvalid, 0);
      chk("mr_bid", m_bid, 0);
      chk("mr_first_grant", s_bready, 8'h01);
      @(negedge clk);
      slv(0, 1'b0, 4'h0, 2'b00);
      slv(5, 1'b0, 4'h0, 2'b00);
      #1;
      chk("mr_first_bid", m_bid, 4'h1);
      chk("mr_first_bvalid", m_bvalid, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
